// File: rtl/rx_frame_parser.sv
// Byte-stream frame parser: HEADER, length byte, then payload bytes, with an idle timeout.
// Optional trailing XOR checksum byte is enabled by defining RX_CHECKSUM_EN.
module rx_frame_parser #(
  parameter logic [7:0] HEADER  = 8'hA5,
  parameter int         MAX_LEN = 16,
  parameter int         TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       arst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_start,
  output logic       frame_done,
  output logic       frame_err,
  output logic [7:0] length_out,
  output logic       busy
);

`ifdef RX_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LEN, DATA, CHK} state_t;
`else
  typedef enum logic [1:0] {IDLE, LEN, DATA} state_t;
`endif

  localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic [7:0]  data_d, len_d;
  logic        dv_d, start_d, done_d, err_d;
  logic        len_ok, last_byte;
`ifdef RX_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  assign len_ok    = (in_data != 8'd0) && (int'(in_data) <= MAX_LEN);
  assign last_byte = (byte_cnt_q + 8'd1) == length_out;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    idle_cnt_d = idle_cnt_q;
    data_d     = data_out;
    len_d      = length_out;
    dv_d       = 1'b0;
    start_d    = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
`ifdef RX_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    if (state_q != IDLE && !in_valid) begin
      // Mid-frame silence: abort once TIMEOUT consecutive idle cycles have elapsed.
      if (idle_cnt_q == TIMEOUT_M1) begin
        err_d      = 1'b1;
        state_d    = IDLE;
        idle_cnt_d = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + 16'd1;
      end
    end else begin
      idle_cnt_d = '0;
      if (in_valid) begin
        case (state_q)
          IDLE: begin
            if (in_data == HEADER) begin
              state_d = LEN;
              start_d = 1'b1;
`ifdef RX_CHECKSUM_EN
              csum_d  = HEADER;
`endif
            end
          end
          LEN: begin
            len_d = in_data;
            if (len_ok) begin
              state_d    = DATA;
              byte_cnt_d = '0;
`ifdef RX_CHECKSUM_EN
              csum_d     = csum_q ^ in_data;
`endif
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
          DATA: begin
            data_d     = in_data;
            dv_d       = 1'b1;
            byte_cnt_d = byte_cnt_q + 8'd1;
`ifdef RX_CHECKSUM_EN
            csum_d     = csum_q ^ in_data;
            if (last_byte) state_d = CHK;
`else
            if (last_byte) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
`endif
          end
`ifdef RX_CHECKSUM_EN
          CHK: begin
            state_d = IDLE;
            if (in_data == csum_q) done_d = 1'b1;
            else                   err_d  = 1'b1;
          end
`endif
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!arst) begin
      // NOTE: reset clears every register, so a frame in flight is dropped without any strobe.
      state_q     <= IDLE;
      byte_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      data_out    <= '0;
      length_out  <= '0;
      data_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
`ifdef RX_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      data_out    <= data_d;
      length_out  <= len_d;
      data_valid  <= dv_d;
      frame_start <= start_d;
      frame_done  <= done_d;
      frame_err   <= err_d;
      busy        <= (state_d != IDLE);
`ifdef RX_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_rx_frame_parser.sv
// Self-checking bench for rx_frame_parser: directed scenarios plus randomized frames
// scored against a frame-level reference model (expected payload queue and strobe counts).
module tb_rx_frame_parser;
  localparam logic [7:0] HDR  = 8'hA5;
  localparam int         MAXL = 16;
  localparam int         TMO  = 64;
  localparam logic [7:0] BIG  = 8'(MAXL + 1);

  logic       clk = 1'b0;
  logic       arst = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic [7:0] data_out, length_out;
  logic       data_valid, frame_start, frame_done, frame_err, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rx_frame_parser #(.HEADER(HDR), .MAX_LEN(MAXL), .TIMEOUT(TMO)) dut (
    .clk(clk), .arst(arst), .in_data(in_data), .in_valid(in_valid),
    .data_out(data_out), .data_valid(data_valid), .frame_start(frame_start),
    .frame_done(frame_done), .frame_err(frame_err), .length_out(length_out), .busy(busy)
  );

  // Passive monitor: strobe counters and captured payload bytes.
  int         n_start = 0, n_done = 0, n_err = 0, n_dv = 0;
  logic [7:0] got_q[$];
  always @(negedge clk) begin
    if (frame_start) n_start++;
    if (frame_done)  n_done++;
    if (frame_err)   n_err++;
    if (data_valid) begin
      n_dv++;
      got_q.push_back(data_out);
    end
  end

  // Present one input beat and return at the falling edge after it was sampled.
  task automatic step(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    @(negedge clk);
  endtask

  task automatic gap(input int maxg);
    int g;
    g = $urandom_range(0, maxg);
    repeat (g) step(1'b0, 8'($urandom));
  endtask

  task automatic do_reset();
    arst = 1'b0;
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    arst = 1'b1;
  endtask

  task automatic test_reset();
    arst = 1'b0;
    step(1'b1, HDR);
    step(1'b1, HDR);
    total++; if ({data_out, length_out, data_valid, frame_start, frame_done, frame_err, busy} !== 21'h0) begin bad++; $display("FAIL reset_outputs: got=%h want=0", {data_out, length_out, data_valid, frame_start, frame_done, frame_err, busy}); end
    arst = 1'b1;
    step(1'b0, 8'h00);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_discard_busy: got=%b want=0", busy); end
  endtask

  task automatic test_basic();
    int s_start;
    logic [7:0] cs;
    do_reset();
    #1 s_start = n_start;
    cs = HDR ^ 8'h03 ^ 8'h11 ^ 8'h22 ^ 8'h33;
    step(1'b1, HDR);
    total++; if ({frame_start, busy, data_valid} !== 3'b110) begin bad++; $display("FAIL basic_hdr: got start,busy,dv=%b want=110", {frame_start, busy, data_valid}); end
    step(1'b1, 8'h03);
    total++; if (length_out !== 8'h03 || frame_start !== 1'b0) begin bad++; $display("FAIL basic_len: got len=%h start=%b want len=03 start=0", length_out, frame_start); end
    step(1'b1, 8'h11);
    total++; if (data_valid !== 1'b1 || data_out !== 8'h11 || frame_done !== 1'b0) begin bad++; $display("FAIL basic_d0: got dv=%b d=%h done=%b want 1/11/0", data_valid, data_out, frame_done); end
    step(1'b1, 8'h22);
    total++; if (data_valid !== 1'b1 || data_out !== 8'h22) begin bad++; $display("FAIL basic_d1: got dv=%b d=%h want 1/22", data_valid, data_out); end
    step(1'b1, 8'h33);
    total++; if (data_valid !== 1'b1 || data_out !== 8'h33) begin bad++; $display("FAIL basic_d2: got dv=%b d=%h want 1/33", data_valid, data_out); end
`ifdef RX_CHECKSUM_EN
    total++; if (frame_done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL basic_pre_chk: got done=%b busy=%b want 0/1", frame_done, busy); end
    step(1'b1, cs);
    total++; if (frame_done !== 1'b1 || data_valid !== 1'b0) begin bad++; $display("FAIL basic_chk_done: got done=%b dv=%b want 1/0", frame_done, data_valid); end
`else
    total++; if (frame_done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL basic_done: got done=%b busy=%b want 1/0 (cs=%h)", frame_done, busy, cs); end
`endif
    step(1'b0, 8'h00);
    total++; if (frame_done !== 1'b0 || data_valid !== 1'b0 || data_out !== 8'h33 || length_out !== 8'h03) begin bad++; $display("FAIL basic_hold: got done=%b dv=%b d=%h len=%h want 0/0/33/03", frame_done, data_valid, data_out, length_out); end
    #1;
    total++; if (n_start - s_start !== 1) begin bad++; $display("FAIL basic_start_count: got=%0d want=1", n_start - s_start); end
  endtask

  task automatic test_junk();
    int s_start, s_done, q0;
    logic [7:0] cs;
    do_reset();
    #1 begin s_start = n_start; s_done = n_done; q0 = got_q.size(); end
    step(1'b1, 8'h00);
    step(1'b1, 8'h7E);
    total++; if (busy !== 1'b0 || frame_start !== 1'b0) begin bad++; $display("FAIL junk_ignored: got busy=%b start=%b want 0/0", busy, frame_start); end
    cs = HDR ^ 8'h02 ^ 8'hAA ^ 8'hBB;
    step(1'b1, HDR);
    step(1'b1, 8'h02);
    step(1'b1, 8'hAA);
    step(1'b1, 8'hBB);
`ifdef RX_CHECKSUM_EN
    step(1'b1, cs);
`endif
    step(1'b0, 8'h00);
    #1;
    total++; if (n_start - s_start !== 1 || n_done - s_done !== 1) begin bad++; $display("FAIL junk_counts: got start=%0d done=%0d want 1/1 (cs=%h)", n_start - s_start, n_done - s_done, cs); end
    total++; if (got_q.size() - q0 !== 2 || got_q[q0] !== 8'hAA || got_q[q0+1] !== 8'hBB) begin bad++; $display("FAIL junk_payload: got n=%0d want AA,BB", got_q.size() - q0); end
  endtask

  task automatic test_bad_len();
    int s_dv, s_done;
    do_reset();
    #1 begin s_dv = n_dv; s_done = n_done; end
    step(1'b1, HDR);
    step(1'b1, 8'h00);
    total++; if (frame_err !== 1'b1 || busy !== 1'b0 || length_out !== 8'h00) begin bad++; $display("FAIL badlen_zero: got err=%b busy=%b len=%h want 1/0/00", frame_err, busy, length_out); end
    step(1'b1, HDR);
    total++; if (frame_err !== 1'b0 || frame_start !== 1'b1) begin bad++; $display("FAIL badlen_restart: got err=%b start=%b want 0/1", frame_err, frame_start); end
    step(1'b1, BIG);
    total++; if (frame_err !== 1'b1 || length_out !== BIG) begin bad++; $display("FAIL badlen_big: got err=%b len=%h want 1/%h", frame_err, length_out, BIG); end
    step(1'b1, 8'h55);
    step(1'b0, 8'h00);
    #1;
    total++; if (n_dv - s_dv !== 0 || n_done - s_done !== 0 || busy !== 1'b0) begin bad++; $display("FAIL badlen_nodata: got dv=%0d done=%0d busy=%b want 0/0/0", n_dv - s_dv, n_done - s_done, busy); end
  endtask

  task automatic test_timeout();
    int s_done;
    logic early;
    do_reset();
    #1 s_done = n_done;
    step(1'b1, HDR);
    step(1'b1, 8'h04);
    step(1'b1, 8'h01);
    step(1'b1, 8'h02);
    early = 1'b0;
    repeat (TMO - 1) begin
      step(1'b0, 8'h00);
      if (frame_err) early = 1'b1;
    end
    total++; if (early !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL timeout_early: got early_err=%b busy=%b want 0/1", early, busy); end
    step(1'b0, 8'h00);
    total++; if (frame_err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL timeout_err: got err=%b busy=%b want 1/0", frame_err, busy); end
    step(1'b1, HDR);
    total++; if (frame_start !== 1'b1 || busy !== 1'b1 || frame_err !== 1'b0) begin bad++; $display("FAIL timeout_restart: got start=%b busy=%b err=%b want 1/1/0", frame_start, busy, frame_err); end
    #1;
    total++; if (n_done - s_done !== 0) begin bad++; $display("FAIL timeout_nodone: got=%0d want=0", n_done - s_done); end
  endtask

  task automatic test_reset_midframe();
    int s_err;
    logic [7:0] cs;
    do_reset();
    #1 s_err = n_err;
    step(1'b1, HDR);
    step(1'b1, 8'h05);
    step(1'b1, 8'h01);
    arst = 1'b0;
    step(1'b1, HDR);
    total++; if ({data_out, length_out, data_valid, frame_start, frame_done, frame_err, busy} !== 21'h0) begin bad++; $display("FAIL midreset_zero: got=%h want=0", {data_out, length_out, data_valid, frame_start, frame_done, frame_err, busy}); end
    arst = 1'b1;
    step(1'b0, 8'h00);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_discard: got busy=%b want 0", busy); end
    cs = HDR ^ 8'h01 ^ 8'h5A;
    step(1'b1, HDR);
    step(1'b1, 8'h01);
    step(1'b1, 8'h5A);
    total++; if (data_valid !== 1'b1 || data_out !== 8'h5A || length_out !== 8'h01) begin bad++; $display("FAIL midreset_data: got dv=%b d=%h len=%h want 1/5A/01", data_valid, data_out, length_out); end
`ifdef RX_CHECKSUM_EN
    step(1'b1, cs);
`endif
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL midreset_done: got=%b want=1 (cs=%h)", frame_done, cs); end
    step(1'b0, 8'h00);
    #1;
    total++; if (n_err - s_err !== 0) begin bad++; $display("FAIL midreset_noerr: got=%0d want=0", n_err - s_err); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] cs;
    do_reset();
    step(1'b1, HDR);
    step(1'b1, 8'h01);
    step(1'b1, 8'hC3);
`ifdef RX_CHECKSUM_EN
    step(1'b1, HDR ^ 8'h01 ^ 8'hC3);
`endif
    step(1'b1, HDR);
    total++; if (frame_start !== 1'b1 || busy !== 1'b1 || frame_done !== 1'b0) begin bad++; $display("FAIL b2b_start: got start=%b busy=%b done=%b want 1/1/0", frame_start, busy, frame_done); end
    cs = HDR ^ 8'h02 ^ 8'h44 ^ 8'h55;
    step(1'b1, 8'h02);
    step(1'b1, 8'h44);
    total++; if (data_valid !== 1'b1 || data_out !== 8'h44) begin bad++; $display("FAIL b2b_data: got dv=%b d=%h want 1/44", data_valid, data_out); end
    step(1'b1, 8'h55);
`ifdef RX_CHECKSUM_EN
    step(1'b1, cs);
`endif
    total++; if (frame_done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL b2b_done: got done=%b busy=%b want 1/0 (cs=%h)", frame_done, busy, cs); end
  endtask

`ifdef RX_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    step(1'b1, HDR); step(1'b1, 8'h02); step(1'b1, 8'h10); step(1'b1, 8'h20);
    step(1'b1, 8'h97);
    total++; if (frame_done !== 1'b1 || frame_err !== 1'b0) begin bad++; $display("FAIL chk_good: got done=%b err=%b want 1/0", frame_done, frame_err); end
    step(1'b1, HDR); step(1'b1, 8'h02); step(1'b1, 8'h10); step(1'b1, 8'h20);
    step(1'b1, 8'h00);
    total++; if (frame_done !== 1'b0 || frame_err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL chk_bad: got done=%b err=%b busy=%b want 0/1/0", frame_done, frame_err, busy); end
  endtask
`endif

  // Frame-level model: each generated frame contributes expected payload bytes and strobe counts.
  task automatic test_random();
    int s_start, s_done, s_err, q0;
    int e_start, e_done, e_err;
    logic [7:0] exp_q[$];
    logic [7:0] exp_len, n, b, cs;
    int kind, k, nj;
    do_reset();
    #1 begin s_start = n_start; s_done = n_done; s_err = n_err; q0 = got_q.size(); end
    e_start = 0; e_done = 0; e_err = 0; exp_len = 8'h00;
    for (int f = 0; f < 40; f++) begin
      nj = $urandom_range(0, 2);
      for (int j = 0; j < nj; j++) begin
        b = 8'($urandom);
        if (b == HDR) b = ~b;
        step(1'b1, b);
        gap(3);
      end
      kind = $urandom_range(0, 9);
      step(1'b1, HDR);
      e_start++;
      gap(4);
      if (kind >= 7 && kind <= 8) begin
        n = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255));
        step(1'b1, n);
        e_err++;
        exp_len = n;
      end else begin
        n = 8'($urandom_range(1, MAXL));
        step(1'b1, n);
        exp_len = n;
        cs = HDR ^ n;
        k = (kind == 9) ? $urandom_range(0, int'(n) - 1) : int'(n);
        for (int i = 0; i < k; i++) begin
          gap(4);
          b = 8'($urandom);
          step(1'b1, b);
          exp_q.push_back(b);
          cs = cs ^ b;
        end
        if (kind == 9) begin
          repeat (TMO) step(1'b0, 8'h00);
          e_err++;
        end else begin
`ifdef RX_CHECKSUM_EN
          gap(4);
          step(1'b1, cs);
`endif
          e_done++;
        end
      end
    end
    step(1'b0, 8'h00);
    #1;
    total++; if (n_start - s_start !== e_start) begin bad++; $display("FAIL rand_start: got=%0d want=%0d", n_start - s_start, e_start); end
    total++; if (n_done - s_done !== e_done) begin bad++; $display("FAIL rand_done: got=%0d want=%0d", n_done - s_done, e_done); end
    total++; if (n_err - s_err !== e_err) begin bad++; $display("FAIL rand_err: got=%0d want=%0d", n_err - s_err, e_err); end
    total++; if (got_q.size() - q0 !== exp_q.size()) begin bad++; $display("FAIL rand_count: got=%0d want=%0d", got_q.size() - q0, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && q0 + i < got_q.size(); i++) begin
      total++; if (got_q[q0+i] !== exp_q[i]) begin bad++; $display("FAIL rand_byte[%0d]: got=%h want=%h", i, got_q[q0+i], exp_q[i]); end
    end
    total++; if (length_out !== exp_len) begin bad++; $display("FAIL rand_len: got=%h want=%h", length_out, exp_len); end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_junk();
    test_bad_len();
    test_timeout();
    test_reset_midframe();
    test_back_to_back();
`ifdef RX_CHECKSUM_EN
    test_checksum();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_frame_parser.md
RX_FRAME_PARSER -- requirements
Module: rx_frame_parser

Interface
REQ-001 The block SHALL expose the parameter HEADER, default 8'hA5, as the frame start byte.
REQ-002 The block SHALL expose the parameter MAX_LEN, default 16, as the largest accepted payload length in bytes (1..255).
REQ-003 The block SHALL expose the parameter TIMEOUT, default 64, as the idle cycles allowed mid-frame between accepted bytes (1..65535).
REQ-004 Port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 Port arst, input, 1: reset, synchronous, active-low.
REQ-006 Port in_data, input, 8: received byte.
REQ-007 Port in_valid, input, 1: in_data is accepted on any clk edge where this is high.
REQ-008 Port data_out, output, 8: payload byte.
REQ-009 Port data_valid, output, 1: one-cycle strobe qualifying data_out.
REQ-010 Port frame_start, output, 1: one-cycle strobe, header accepted.
REQ-011 Port frame_done, output, 1: one-cycle strobe, frame completed without error.
REQ-012 Port frame_err, output, 1: one-cycle strobe, frame aborted.
REQ-013 Port length_out, output, 8: length field of the current or last frame.
REQ-014 Port busy, output, 1: high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, LEN and DATA, plus CHK when RX_CHECKSUM_EN is defined.
REQ-016 In IDLE, an accepted byte equal to HEADER SHALL move the FSM to LEN and pulse frame_start on the next cycle; the FSM SHALL ignore all other bytes.
REQ-017 In LEN, an accepted byte N with 1<=N<=MAX_LEN SHALL load length_out=N, clear the byte counter and move the FSM to DATA.
REQ-018 In LEN, N=0 or N>MAX_LEN SHALL pulse frame_err, return the FSM to IDLE and still update length_out to N.
REQ-019 In DATA, each accepted byte SHALL appear on data_out with data_valid high exactly 1 cycle after acceptance, and the byte counter SHALL increment.
REQ-020 When the N-th data byte is accepted, the FSM SHALL go to IDLE and pulse frame_done in the same cycle as that byte's data_valid; with RX_CHECKSUM_EN defined, it SHALL go to CHK instead and SHALL NOT pulse frame_done.
REQ-021 The block SHALL process a header accepted on the cycle immediately after frame completion normally, with no dead cycle.
REQ-022 The idle counter SHALL reset on every accepted byte and count cycles with in_valid low while in LEN, DATA or CHK.
REQ-023 When the idle counter reaches TIMEOUT, the block SHALL pulse frame_err and return the FSM to IDLE.
REQ-024 All outputs SHALL be registered, and strobes SHALL be high for exactly one cycle.
REQ-025 data_out SHALL hold its last value when data_valid is low.
REQ-026 A bad length or timeout SHALL NOT produce frame_done.

Reset
REQ-027 While arst is low at a clk edge, the block SHALL set state=IDLE, data_out=8'h00, length_out=8'h00, clear all strobes, set busy=0 and clear both counters.
REQ-028 A reset asserted mid-frame SHALL abort the frame silently, with no frame_err, and bytes accepted while in reset SHALL be discarded.

Configuration
REQ-029 With RX_CHECKSUM_EN defined, the byte in CHK SHALL be compared with the XOR of the header, length and all data bytes.
REQ-030 With RX_CHECKSUM_EN defined, a checksum match SHALL pulse frame_done and a mismatch SHALL pulse frame_err, 1 cycle after the checksum byte; either way the FSM SHALL return to IDLE.
REQ-031 Without RX_CHECKSUM_EN, the CHK state, the XOR register and the comparison SHALL be absent, and the frame SHALL end at the last data byte.

Verification
REQ-032 Stream A5,03,11,22,33 with back-to-back in_valid -> frame_start once; data_valid 3 cycles with 11,22,33; frame_done with the 33 strobe; length_out=03.
REQ-033 Stream 00,7E,A5,02,AA,BB -> leading 00,7E ignored; one frame of AA,BB; busy low before A5.
REQ-034 Stream A5,00, then A5,11 (MAX_LEN=16) -> frame_err for each; length_out=11; no data_valid.
REQ-035 Stream A5,04,01,02 followed by 64 idle cycles -> frame_err on timeout; busy low afterwards; a next A5 restarts the FSM.
REQ-036 Drive arst low for one cycle after A5,05,01 -> all outputs zero; no frame_err; frame A5,01,5A then parses normally.
REQ-037 With RX_CHECKSUM_EN defined, stream A5,02,10,20,97 -> frame_done; stream A5,02,10,20,00 -> frame_err.
